enc_arb: RTL

- Shares one 128-bit SECDED encoder (enc_top, 128 data bits to 137 codeword bits) between NREQ requesters.
- Typical requesters: the write path and the memory scrubber.
- Each cycle, picks at most one requester by round-robin, encodes its data and registers the result with a valid/ready handshake towards the memory write port.
- Sits between request sources and the ECC-protected array.

---
 rtl/enc_pkg.sv | 17 +
 rtl/enc_top.sv | 42 ++++
 rtl/rr_arb.sv | 38 +++
 rtl/enc_arb.sv | 101 ++++++++++
 4 files changed

// File: rtl/enc_pkg.sv
// enc_pkg: shared constants and helpers for the SECDED encoder and the
// encoder arbiter.
//   ENC_DW : data width fed to the encoder (128)
//   ENC_CW : codeword width produced by the encoder (137)
//   ENC_PW : parity bits in a codeword (8 Hamming + 1 overall)
//   idx_w  : width of an index into n requesters, never less than 1
package enc_pkg;

  localparam int ENC_DW = 128;
  localparam int ENC_CW = 137;
  localparam int ENC_PW = 9;

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/enc_top.sv
// enc_top: combinational 128-bit SECDED encoder (Hamming(136,128) plus an
// overall parity bit).
// Ports:
//   clk  in   1        present for interface compatibility, not used
//   IN   in   ENC_DW   data word
//   OUT  out  ENC_CW   codeword {overall_parity, hamming[7:0], data[127:0]}
// Data bit k sits at the k-th non-power-of-two Hamming position (3,5,6,7,9,...);
// Hamming bit j covers every position with bit j set. The overall parity
// bit makes the whole 137-bit codeword even-parity.
module enc_top
  import enc_pkg::*;
(
  input  logic              clk,
  input  logic [ENC_DW-1:0] IN,
  output logic [ENC_CW-1:0] OUT
);

  logic unused_clk;
  assign unused_clk = clk;

  function automatic logic [ENC_PW-2:0] hamming(input logic [ENC_DW-1:0] d);
    logic [ENC_PW-2:0] p;
    int k;
    p = '0;
    k = 0;
    for (int pos = 1; pos <= ENC_DW + ENC_PW - 1; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        for (int j = 0; j < ENC_PW - 1; j++) begin
          if (pos[j]) p[j] = p[j] ^ d[k];
        end
        k++;
      end
    end
    return p;
  endfunction

  logic [ENC_PW-2:0] ham;

  assign ham = hamming(IN);
  assign OUT = {^{ham, IN}, ham, IN};

endmodule

// File: rtl/rr_arb.sv
// rr_arb: combinational round-robin arbiter.
// Ports:
//   req      in   NREQ  request vector
//   last     in   IDW   index granted most recently
//   en       in   1     allow a grant this cycle
//   gnt      out  NREQ  one-hot grant (zero when en=0 or no request)
//   gnt_idx  out  IDW   index of the winning request (valid even when en=0)
// The search starts just above last and wraps, so the previous winner has
// the lowest priority. The pointer itself is owned by the caller.
module rr_arb
  import enc_pkg::*;
#(
  parameter  int NREQ = 2,
  localparam int IDW  = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_idx
);

  logic found;

  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    gnt     = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!found && req[(int'(last) + k) % NREQ]) begin
        found   = 1'b1;
        gnt_idx = IDW'((int'(last) + k) % NREQ);
      end
    end
    gnt[gnt_idx] = en && found;
  end

endmodule

// File: rtl/enc_arb.sv
// enc_arb: shares one SECDED encoder between NREQ requesters, with a
// registered codeword output.
// Ports:
//   clk        in   1        clock, posedge
//   rst        in   1        synchronous reset, active high
//   req_valid  in   NREQ     per-requester valid
//   req_data   in   NREQ*DW  requester i at [i*DW +: DW]
//   req_ready  out  NREQ     one-hot or zero accept
//   out_valid  out  1        codeword register full
//   out_ready  in   1        downstream accepts codeword
//   out_code   out  CW       registered codeword
//   out_id     out  IDW      requester that produced out_code
//   busy       out  1        out_valid or any req_valid
// Optional macro ENC_ARB_ERRINJ_EN adds inj_en / inj_mask: the mask is
// XORed into a codeword as it is loaded, for fault injection downstream.
//
// Handshake: a transfer happens on a posedge where valid && ready are both
// high; ready never depends on the same side's valid being absent, a
// source holds valid/data stable until it sees ready, and the output
// register only loads when it is empty or being drained (can_load).
module enc_arb
  import enc_pkg::*;
#(
  parameter  int NREQ = 2,
  parameter  int DW   = ENC_DW,
  parameter  int CW   = ENC_CW,
  localparam int IDW  = idx_w(NREQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req_valid,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]  req_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    out_code,
  output logic [IDW-1:0]   out_id,
  output logic             busy
`ifdef ENC_ARB_ERRINJ_EN
  ,
  input  logic             inj_en,
  input  logic [CW-1:0]    inj_mask
`endif
);

  logic [IDW-1:0]  last_gnt;
  logic [IDW-1:0]  gnt_idx;
  logic [NREQ-1:0] gnt;
  logic            can_load;
  logic            fire;
  logic [DW-1:0]   sel_data;
  logic [CW-1:0]   enc_code;
  logic [CW-1:0]   load_code;

  assign can_load = !out_valid || out_ready;

  // Gating en with rst keeps req_ready low during reset cycles.
  rr_arb #(.NREQ(NREQ)) u_arb (
    .req     (req_valid),
    .last    (last_gnt),
    .en      (can_load && !rst),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign req_ready = gnt;
  assign fire      = |gnt;
  assign sel_data  = req_data[gnt_idx*DW +: DW];

  enc_top u_enc (
    .clk (clk),
    .IN  (sel_data),
    .OUT (enc_code)
  );

`ifdef ENC_ARB_ERRINJ_EN
  assign load_code = inj_en ? (enc_code ^ inj_mask) : enc_code;
`else
  assign load_code = enc_code;
`endif

  assign busy = out_valid || (|req_valid);

  // The pointer only moves on a fire, so backpressure (no fire) freezes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_code  <= '0;
      out_id    <= '0;
      last_gnt  <= IDW'(NREQ - 1);
    end else if (fire) begin
      out_valid <= 1'b1;
      out_code  <= load_code;
      out_id    <= gnt_idx;
      last_gnt  <= gnt_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
